vram_write_arbiter: RTL and testbench

//  Shares the single VRAM write port between two requesters: port 0 (main CPU

---
 rtl/vram_write_arbiter.sv | 178 +++++++++++++++++
 tb/tb_vram_write_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_write_arbiter.sv
// -----------------------------------------------------------------------------
// vram_write_arbiter
//   Shares the single VRAM write port between the CPU pixel path (port 0) and
//   the blitter/clear engine (port 1). Round-robin between the two ports, with
//   bursts capped at MAX_BURST words. Port 1 can be limited to vertical blank
//   so that the blitter never tears the visible frame.
//
// Ports
//   clk                    system clock
//   reset                  asynchronous active-low reset
//   req0/addr0/data0       port 0 word offer (addr/data stable while req0=1)
//   ready0                 port 0 word taken on an edge with req0&ready0
//   req1/addr1/data1       port 1 word offer
//   ready1                 port 1 word taken on an edge with req1&ready1
//   vblank                 vertical blank from the video clock domain (async)
//   vram_we/addr/data      registered VRAM write port
//   grant                  registered arbiter state (00 idle, 01 port0, 10 port1)
// -----------------------------------------------------------------------------
module vram_write_arbiter #(
    parameter int ADDR_WIDTH   = 15,
    parameter int DATA_WIDTH   = 12,
    parameter int MAX_BURST    = 16,
    parameter int VBLANK_ONLY1 = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] data0,
    output logic                  ready0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  ready1,
    input  logic                  vblank,
    output logic                  vram_we,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic [DATA_WIDTH-1:0] vram_data,
    output logic [1:0]            grant
);

    // state     | meaning
    // ST_IDLE   | no port owns the VRAM write port
    // ST_GRANT0 | port 0 owns the write port, burst in progress
    // ST_GRANT1 | port 1 owns the write port, burst in progress
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GRANT0 = 2'b01,
        ST_GRANT1 = 2'b10
    } state_t;

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic              vblank_meta_q, vblank_sync_q;
    logic              vram_we_q;
    logic [ADDR_WIDTH-1:0] vram_addr_q;
    logic [DATA_WIDTH-1:0] vram_data_q;

    logic gate1;
    logic elig0, elig1;
    logic xfer0, xfer1;
    logic rearb;
    logic pick_last;

    // Two-flop synchronizer for the video-domain vblank.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vblank_meta_q <= 1'b0;
            vblank_sync_q <= 1'b0;
        end else begin
            vblank_meta_q <= vblank;
            vblank_sync_q <= vblank_meta_q;
        end
    end

    // Port 1 may only write during blank when gating is enabled.
    assign gate1  = (VBLANK_ONLY1 == 0) || vblank_sync_q;
    assign elig0  = req0;
    assign elig1  = req1 && gate1;

    // Ready depends on state and sync'd vblank only, never on req.
    assign ready0 = (state_q == ST_GRANT0);
    assign ready1 = (state_q == ST_GRANT1) && gate1;
    assign xfer0  = req0 && ready0;
    assign xfer1  = req1 && ready1;

    // Round-robin choice: on a tie the port that did not go last wins.
    function automatic state_t pick(input logic lst, input logic e0, input logic e1);
        state_t s;
        if (e0 && e1)  s = lst ? ST_GRANT0 : ST_GRANT1;
        else if (e0)   s = ST_GRANT0;
        else if (e1)   s = ST_GRANT1;
        else           s = ST_IDLE;
        return s;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        rearb       = 1'b0;
        pick_last   = last_q;
        case (state_q)
            ST_IDLE: begin
                rearb     = 1'b1;
                pick_last = last_q;
            end
            ST_GRANT0: begin
                if (xfer0 && (burst_cnt_q != CNT_LAST)) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end else begin
                    rearb     = 1'b1;
                    pick_last = 1'b0;
                end
            end
            ST_GRANT1: begin
                // Also ends when vblank gating removes ready1 mid-burst.
                if (xfer1 && (burst_cnt_q != CNT_LAST)) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end else begin
                    rearb     = 1'b1;
                    pick_last = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Re-arbitration switches ports directly, without an idle bubble.
        if (rearb) begin
            state_d     = pick(pick_last, elig0, elig1);
            burst_cnt_d = '0;
            if (state_d != ST_IDLE) begin
                last_d = (state_d == ST_GRANT1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vram_we_q   <= 1'b0;
            vram_addr_q <= '0;
            vram_data_q <= '0;
        end else begin
            vram_we_q <= xfer0 || xfer1;
            if (xfer0) begin
                vram_addr_q <= addr0;
                vram_data_q <= data0;
            end else if (xfer1) begin
                vram_addr_q <= addr1;
                vram_data_q <= data1;
            end
        end
    end

    assign vram_we   = vram_we_q;
    assign vram_addr = vram_addr_q;
    assign vram_data = vram_data_q;
    assign grant     = state_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
module tb_vram_write_arbiter;

    localparam int AW   = 15;
    localparam int DW   = 12;
    localparam int MAXB = 16;
    localparam int VB   = 1;

    logic          clk;
    logic          reset;
    logic          req0, req1, vblank;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] data0, data1;
    logic          ready0, ready1, vram_we;
    logic [AW-1:0] vram_addr;
    logic [DW-1:0] vram_data;
    logic [1:0]    grant;

    int checks = 0;
    int errors = 0;

    vram_write_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MAXB), .VBLANK_ONLY1(VB)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .data0(data0), .ready0(ready0),
        .req1(req1), .addr1(addr1), .data1(data1), .ready1(ready1),
        .vblank(vblank),
        .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data),
        .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: who owns the port, how many words this burst,
    // which port went last, and vblank as seen two edges late.
    int            m_owner;   // 0 none, 1 port 0, 2 port 1
    int            m_last;    // port index (0/1) that was granted most recently
    int            m_words;   // words moved in the current burst
    bit            m_vs1, m_vs2;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            m_x0, m_x1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_last = 1; m_words = 0;
        m_vs1 = 0; m_vs2 = 0;
        m_we = 0; m_addr = '0; m_data = '0;
        m_x0 = 0; m_x1 = 0;
    endtask

    function automatic int model_pick(input int lastp, input bit e0, input bit e1);
        if (e0 && e1) return (lastp == 0) ? 2 : 1;
        if (e0) return 1;
        if (e1) return 2;
        return 0;
    endfunction

    task automatic compare_model();
        bit gate;
        gate = (VB == 0) || m_vs2;
        chk("grant",     32'(grant),     32'(m_owner));
        chk("ready0",    32'(ready0),    32'(m_owner == 1));
        chk("ready1",    32'(ready1),    32'(m_owner == 2 && gate));
        chk("vram_we",   32'(vram_we),   32'(m_we));
        chk("vram_addr", 32'(vram_addr), 32'(m_addr));
        chk("vram_data", 32'(vram_data), 32'(m_data));
    endtask

    // Advance the model over one clock edge using the inputs now applied,
    // then compare every output shortly after the edge.
    task automatic step();
        bit gate, r0, r1, x0, x1, e1, moved;
        int n_owner;
        gate = (VB == 0) || m_vs2;
        r0 = (m_owner == 1);
        r1 = (m_owner == 2) && gate;
        x0 = req0 && r0;
        x1 = req1 && r1;
        e1 = req1 && gate;
        n_owner = m_owner;
        if (m_owner == 0) begin
            n_owner = model_pick(m_last, req0, e1);
            if (n_owner != 0) begin m_last = n_owner - 1; m_words = 0; end
        end else begin
            moved = (m_owner == 1) ? x0 : x1;
            if (moved && (m_words + 1 < MAXB)) begin
                m_words++;
            end else begin
                n_owner = model_pick(m_owner - 1, req0, e1);
                m_words = 0;
                if (n_owner != 0) m_last = n_owner - 1;
            end
        end
        @(posedge clk);
        #1;
        m_owner = n_owner;
        m_x0 = x0; m_x1 = x1;
        m_we = x0 || x1;
        if (x0) begin m_addr = addr0; m_data = data0; end
        else if (x1) begin m_addr = addr1; m_data = data1; end
        m_vs2 = m_vs1;
        m_vs1 = vblank;
        compare_model();
    endtask

    task automatic async_reset_pulse();
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("rst_vram_we", 32'(vram_we), 32'd0);
        chk("rst_grant",   32'(grant),   32'd0);
        compare_model();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        req0 = 0; req1 = 0; vblank = 0;
        addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        model_reset();
        #1;
        compare_model();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Single port-0 word.
        req0 = 1; addr0 = 15'h0010; data0 = 12'hF00;
        step();
        chk("t1_grant", 32'(grant), 32'd1);
        step();
        chk("t1_we",   32'(vram_we),   32'd1);
        chk("t1_addr", 32'(vram_addr), 32'h0010);
        chk("t1_data", 32'(vram_data), 32'hF00);
        req0 = 0;
        step();
        chk("t1_idle", 32'(grant), 32'd0);

        // Port 1 blocked outside vblank.
        req1 = 1; addr1 = 15'h00AA; data1 = 12'h0F0;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("t3_ready1", 32'(ready1),  32'd0);
            chk("t3_we",     32'(vram_we), 32'd0);
        end
        vblank = 1;
        step();
        step();
        chk("t3_grant_wait", 32'(grant), 32'd0);
        step();
        chk("t3_grant1", 32'(grant), 32'd2);

        // vblank drops mid port-1 burst.
        for (int i = 0; i < 8; i++) step();
        vblank = 0;
        step();
        step();
        chk("t4_ready1_low", 32'(ready1),  32'd1 - 32'd1);
        chk("t4_last_write", 32'(vram_we), 32'd1);
        step();
        chk("t4_no_write", 32'(vram_we), 32'd0);
        chk("t4_grant",    32'(grant),   32'd0);

        // Sustained contention from reset: alternating 16-word bursts.
        req0 = 0; req1 = 0;
        async_reset_pulse();
        req0 = 1; req1 = 1; vblank = 1;
        addr0 = 15'h0100; addr1 = 15'h0200;
        step();
        step();
        for (int k = 0; k < 64; k++) begin
            chk("t2_we",   32'(vram_we),   32'd1);
            chk("t2_addr", 32'(vram_addr), ((k / 16) % 2 == 1) ? 32'h200 : 32'h100);
            step();
        end

        // Reset mid-burst, then port 0 takes the first grant.
        async_reset_pulse();
        step();
        chk("t6_grant0", 32'(grant), 32'd1);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if (m_x0) begin
                req0 = ($urandom_range(0, 3) != 0);
                addr0 = AW'($urandom); data0 = DW'($urandom);
            end else if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1;
                addr0 = AW'($urandom); data0 = DW'($urandom);
            end
            if (m_x1) begin
                req1 = ($urandom_range(0, 4) != 0);
                addr1 = AW'($urandom); data1 = DW'($urandom);
            end else if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1;
                addr1 = AW'($urandom); data1 = DW'($urandom);
            end else if (req1 && $urandom_range(0, 31) == 0) begin
                req1 = 0;
            end
            if ($urandom_range(0, 24) == 0) vblank = !vblank;
            if ($urandom_range(0, 599) == 0) async_reset_pulse();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
